kv_store: RTL and testbench
===========================

KV_STORE -- requirements
Module: kv_store

Interface
REQ-001 The module SHALL have a parameter DEPTH, default 8, giving the number of table entries (power of two, 2..16).
REQ-002 The module SHALL have port tick_in, input, width 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-004 The module SHALL have port signal, input, width 2: request code; 2 = transaction, 3 = clear table, 0/1 = idle.
REQ-005 The module SHALL have port transact_kind, input, width 1: 1 = put (write), 0 = get (read); sampled only with signal=2.
REQ-006 The module SHALL have port key, input, width 32: lookup key.
REQ-007 The module SHALL have port transact_value, input, width 32: value for put; ignored for get.
REQ-008 The module SHALL have port busy, output, width 1: high from the acceptance edge until the response cycle ends.
REQ-009 The module SHALL have port resp_valid, output, width 1: one-cycle response pulse.
REQ-010 The module SHALL have port resp_status, output, width 2: 0 = hit/ok, 1 = get miss, 2 = put inserted new entry, 3 = put dropped because the table is full.
REQ-011 The module SHALL have port resp_value, output, width 32: stored value on get hit; 0 otherwise.
REQ-012 The module SHALL have port count, output, width clog2(DEPTH)+1: number of valid entries.
REQ-013 The module SHALL have port full, output, width 1: count == DEPTH.

Function
REQ-014 Acceptance SHALL be edge-qualified: a request is accepted on a clock edge where signal is 2 or 3, the signal value registered on the previous edge differs from the current one, and busy is 0.
REQ-015 A request that is held at a constant level SHALL be accepted once only.
REQ-016 Requests arriving while busy=1 SHALL be ignored, not queued.
REQ-017 key, transact_value and transact_kind SHALL be captured into internal registers on the acceptance edge.
REQ-018 The FSM SHALL have exactly the states IDLE, SCAN, COMMIT and RESP.
REQ-019 A transaction SHALL take IDLE->SCAN at acceptance; SCAN SHALL examine entries 0..DEPTH-1, one per cycle, with no early exit; the last entry SHALL lead to COMMIT; COMMIT SHALL lead to RESP; RESP SHALL return to IDLE.
REQ-020 During SCAN the block SHALL record the hit index (a valid entry whose key equals the captured key) and the lowest-numbered invalid entry.
REQ-021 COMMIT for a put hit SHALL overwrite the stored value with status 0.
REQ-022 COMMIT for a put miss with a free entry SHALL write key and value into the lowest free entry, set its valid bit and increment count, with status 2.
REQ-023 COMMIT for a put miss with the table full SHALL leave the table unchanged, with status 3.
REQ-024 COMMIT for a get hit SHALL latch the stored value with status 0; a get miss SHALL latch value 0 with status 1.
REQ-025 In RESP, resp_valid SHALL be 1 for exactly one cycle with resp_status and resp_value stable.
REQ-026 resp_value and resp_status SHALL hold until the next response.
REQ-027 Transaction latency SHALL be fixed: resp_valid is high in cycle DEPTH+2 after the acceptance edge (cycle 10 for DEPTH=8).
REQ-028 A clear request SHALL take IDLE->COMMIT directly, invalidate all entries and set count to 0.
REQ-029 A clear response SHALL be resp_valid the cycle after COMMIT with status 0 and value 0.
REQ-030 The table SHALL never hold duplicate keys.
REQ-031 Key 0 and value 0 SHALL be legal data.
REQ-032 Stale key/value data in invalid entries SHALL never produce a hit.

Reset
REQ-033 rst_n low SHALL force the state to IDLE and clear all valid bits.
REQ-034 rst_n low SHALL set busy, resp_valid, resp_status, resp_value, count and full to 0, and the registered previous signal to 0.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction with no response pulse and leave the table empty.
REQ-036 If signal is held at 2 when rst_n is released, the request SHALL be accepted on the first clock edge after release.

Verification
REQ-037 The bench SHALL cover put key=0x00000001 value=0xDEADBEEF, then get key=1 -> put: status 2, count 1; get: status 0, resp_value 0xDEADBEEF, resp_valid at cycle 10 after acceptance.
REQ-038 The bench SHALL cover put key=5 value=7, then put key=5 value=9, then get key=5 -> statuses 2 then 0, count stays 1, get returns 9.
REQ-039 The bench SHALL cover 8 puts with distinct keys followed by a 9th new key -> full=1 after the 8th; the 9th returns status 3; a get of the 9th key returns status 1, value 0.
REQ-040 The bench SHALL cover signal held at 2 for 30 cycles -> exactly one resp_valid pulse; a second edge arriving while busy produces no extra response.
REQ-041 The bench SHALL cover a clear after 3 puts, then a get of one of those keys -> count 0, full 0; the get returns status 1.
REQ-042 The bench SHALL cover rst_n pulsed low during SCAN of a put -> no resp_valid, count 0, and a following get of that key returns status 1.

Source files
------------

// File: rtl/kv_store.sv
// kv_store: small fully-associative key/value table with a fixed-latency
// linear scan. A put or get always takes DEPTH+2 cycles so that the response
// time does not depend on where (or whether) the key is found.
//
// Ports:
//   tick_in        clock, all state changes on its rising edge
//   rst_n          asynchronous active-low reset
//   signal         request code: 2 = transaction, 3 = clear, 0/1 = idle
//   transact_kind  1 = put, 0 = get (sampled with signal=2)
//   key            lookup key
//   transact_value value for a put
//   busy           high from acceptance until the response cycle ends
//   resp_valid     one-cycle response pulse
//   resp_status    0 hit/ok, 1 get miss, 2 put inserted, 3 put dropped (full)
//   resp_value     stored value on get hit, else 0; held until next response
//   count          number of valid entries
//   full           count == DEPTH
module kv_store #(
    parameter int DEPTH = 8
) (
    input  logic                     tick_in,
    input  logic                     rst_n,
    input  logic [1:0]               signal,
    input  logic                     transact_kind,
    input  logic [31:0]              key,
    input  logic [31:0]              transact_value,
    output logic                     busy,
    output logic                     resp_valid,
    output logic [1:0]               resp_status,
    output logic [31:0]              resp_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;

    state_t          state, next;
    logic [1:0]      prev_sig;
    logic            accept;

    logic [IW-1:0]   idx;
    logic            cap_kind;
    logic [31:0]     cap_key;
    logic [31:0]     cap_val;
    logic            is_clear;
    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic            free;
    logic [IW-1:0]   free_idx;

    logic [DEPTH-1:0] valid;
    logic [31:0]      keys [DEPTH];
    logic [31:0]      vals [DEPTH];

    // Edge-qualified acceptance: a level held on signal is taken only once,
    // and anything arriving while busy is dropped rather than queued.
    assign accept     = (signal == 2'd2 || signal == 2'd3) && (signal != prev_sig) && !busy;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign full       = (count == CW'(DEPTH));

    always_ff @(posedge tick_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   if (accept) next = (signal == 2'd2) ? SCAN : COMMIT;
            SCAN:   if (idx == IW'(DEPTH - 1)) next = COMMIT;
            COMMIT: next = RESP;
            RESP:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge tick_in or negedge rst_n) begin
        if (!rst_n) begin
            prev_sig    <= 2'd0;
            idx         <= '0;
            cap_kind    <= 1'b0;
            cap_key     <= '0;
            cap_val     <= '0;
            is_clear    <= 1'b0;
            hit         <= 1'b0;
            hit_idx     <= '0;
            free        <= 1'b0;
            free_idx    <= '0;
            valid       <= '0;
            count       <= '0;
            resp_status <= 2'd0;
            resp_value  <= '0;
        end else begin
            prev_sig <= signal;
            case (state)
                IDLE: if (accept) begin
                    idx      <= '0;
                    cap_kind <= transact_kind;
                    cap_key  <= key;
                    cap_val  <= transact_value;
                    is_clear <= (signal == 2'd3);
                    hit      <= 1'b0;
                    free     <= 1'b0;
                end
                SCAN: begin
                    // Valid bit gates the compare so stale entries never hit.
                    if (valid[idx] && keys[idx] == cap_key) begin
                        hit     <= 1'b1;
                        hit_idx <= idx;
                    end
                    if (!valid[idx] && !free) begin
                        free     <= 1'b1;
                        free_idx <= idx;
                    end
                    idx <= idx + 1'b1;
                end
                COMMIT: begin
                    resp_value <= '0;
                    if (is_clear) begin
                        valid       <= '0;
                        count       <= '0;
                        resp_status <= 2'd0;
                    end else if (cap_kind) begin
                        if (hit) begin
                            resp_status <= 2'd0;
                        end else if (free) begin
                            valid[free_idx] <= 1'b1;
                            count           <= count + CW'(1);
                            resp_status     <= 2'd2;
                        end else begin
                            resp_status <= 2'd3;
                        end
                    end else if (hit) begin
                        resp_status <= 2'd0;
                        resp_value  <= vals[hit_idx];
                    end else begin
                        resp_status <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key/value storage needs no reset: only the valid bits give it meaning.
    always_ff @(posedge tick_in) begin
        if (state == COMMIT && !is_clear && cap_kind && (hit || free)) begin
            keys[hit ? hit_idx : free_idx] <= cap_key;
            vals[hit ? hit_idx : free_idx] <= cap_val;
        end
    end

endmodule

// File: tb/tb_kv_store.sv
module tb_kv_store;

    localparam int DEPTH = 8;

    logic        tick_in = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  signal = 2'd0;
    logic        transact_kind = 1'b0;
    logic [31:0] key = '0;
    logic [31:0] transact_value = '0;
    logic        busy, resp_valid, full;
    logic [1:0]  resp_status;
    logic [31:0] resp_value;
    logic [3:0]  count;

    int tests = 0;
    int failed = 0;
    int lat, pulses;
    logic [1:0]  st;
    logic [31:0] vl;

    kv_store #(.DEPTH(DEPTH)) dut (
        .tick_in(tick_in), .rst_n(rst_n), .signal(signal),
        .transact_kind(transact_kind), .key(key), .transact_value(transact_value),
        .busy(busy), .resp_valid(resp_valid), .resp_status(resp_status),
        .resp_value(resp_value), .count(count), .full(full)
    );

    always #5 tick_in = ~tick_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of cycle 1 after acceptance; returns the cycle
    // number in which resp_valid is seen (41 on timeout).
    task automatic wait_resp(output int n, output logic [1:0] s, output logic [31:0] v);
        n = 1;
        while (!resp_valid && n <= 40) begin
            @(negedge tick_in);
            n++;
        end
        s = resp_status;
        v = resp_value;
    endtask

    task automatic txn(input logic [1:0] sg, input logic kind, input logic [31:0] k,
                       input logic [31:0] v, output int n, output logic [1:0] s,
                       output logic [31:0] rv);
        @(negedge tick_in);
        signal = sg; transact_kind = kind; key = k; transact_value = v;
        @(posedge tick_in);
        @(negedge tick_in);
        signal = 2'd0;
        wait_resp(n, s, rv);
    endtask

    initial begin
        repeat (2) @(negedge tick_in);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_status", resp_status, 0);
        chk("rst_value", resp_value, 0);
        rst_n = 1'b1;

        // put 1/DEADBEEF then get 1
        txn(2'd2, 1'b1, 32'h1, 32'hDEADBEEF, lat, st, vl);
        chk("put1_lat", lat, 10);
        chk("put1_status", st, 2);
        chk("put1_count", count, 1);
        txn(2'd2, 1'b0, 32'h1, 32'h0, lat, st, vl);
        chk("get1_lat", lat, 10);
        chk("get1_status", st, 0);
        chk("get1_value", vl, 32'hDEADBEEF);
        @(negedge tick_in);
        chk("resp_pulse_one_cycle", resp_valid, 0);
        chk("value_held", resp_value, 32'hDEADBEEF);

        // overwrite of an existing key
        txn(2'd3, 1'b0, 32'h0, 32'h0, lat, st, vl);
        chk("clr_lat", lat, 2);
        chk("clr_count", count, 0);
        txn(2'd2, 1'b1, 32'h5, 32'h7, lat, st, vl);
        chk("put5a_status", st, 2);
        txn(2'd2, 1'b1, 32'h5, 32'h9, lat, st, vl);
        chk("put5b_status", st, 0);
        chk("put5b_count", count, 1);
        txn(2'd2, 1'b0, 32'h5, 32'h0, lat, st, vl);
        chk("get5_status", st, 0);
        chk("get5_value", vl, 32'h9);

        // fill the table (key 0 / value 0 included), then overflow
        txn(2'd3, 1'b0, 32'h0, 32'h0, lat, st, vl);
        for (int i = 0; i < DEPTH; i++) begin
            txn(2'd2, 1'b1, 32'(i), 32'(i * 3), lat, st, vl);
            chk("fill_status", st, 2);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        txn(2'd2, 1'b1, 32'd100, 32'h55, lat, st, vl);
        chk("put9_status", st, 3);
        chk("put9_count", count, 8);
        txn(2'd2, 1'b0, 32'd100, 32'h0, lat, st, vl);
        chk("get9_status", st, 1);
        chk("get9_value", vl, 0);
        txn(2'd2, 1'b0, 32'd0, 32'h0, lat, st, vl);
        chk("get_key0_status", st, 0);
        txn(2'd2, 1'b0, 32'd7, 32'h0, lat, st, vl);
        chk("get7_value", vl, 32'd21);

        // level held for 30 cycles, with an extra edge while busy
        @(negedge tick_in);
        signal = 2'd2; transact_kind = 1'b0; key = 32'd3;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge tick_in);
            if (resp_valid) pulses++;
            if (i == 3) signal = 2'd3;
            if (i == 4) signal = 2'd2;
        end
        signal = 2'd0;
        chk("held_pulses", pulses, 1);
        chk("held_value", resp_value, 32'd9);
        chk("held_count", count, 8);

        // clear after three puts
        txn(2'd3, 1'b0, 32'h0, 32'h0, lat, st, vl);
        txn(2'd2, 1'b1, 32'd10, 32'hA, lat, st, vl);
        txn(2'd2, 1'b1, 32'd11, 32'hB, lat, st, vl);
        txn(2'd2, 1'b1, 32'd12, 32'hC, lat, st, vl);
        chk("three_count", count, 3);
        txn(2'd3, 1'b0, 32'h0, 32'h0, lat, st, vl);
        chk("clr3_status", st, 0);
        chk("clr3_value", vl, 0);
        chk("clr3_count", count, 0);
        chk("clr3_full", full, 0);
        txn(2'd2, 1'b0, 32'd11, 32'h0, lat, st, vl);
        chk("get_after_clr", st, 1);

        // reset during SCAN of a put
        txn(2'd2, 1'b1, 32'd10, 32'h1, lat, st, vl);
        chk("pre_abort_count", count, 1);
        @(negedge tick_in);
        signal = 2'd2; transact_kind = 1'b1; key = 32'h55; transact_value = 32'h77;
        @(posedge tick_in);
        @(negedge tick_in);
        signal = 2'd0;
        repeat (2) @(negedge tick_in);
        chk("abort_in_scan", busy, 1);
        rst_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tick_in);
            if (resp_valid) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge tick_in);
            if (resp_valid) pulses++;
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);

        // signal held at 2 across reset release: accepted on first edge
        rst_n = 1'b0;
        signal = 2'd2; transact_kind = 1'b0; key = 32'h55;
        @(negedge tick_in);
        rst_n = 1'b1;
        @(posedge tick_in);
        @(negedge tick_in);
        signal = 2'd0;
        wait_resp(lat, st, vl);
        chk("rel_accept_lat", lat, 10);
        chk("abort_get_status", st, 1);
        chk("abort_get_value", vl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
